// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- parametrised inter-stage pipeline register (IF/ID .. MEM/WB).
//
// Carries PC, instruction, control word and NUM_DATA data words through a
// two-entry skid buffer (main + skid) with a valid/ready handshake. in_ready
// is a flop, so downstream back-pressure never forms a combinational path
// back upstream. A flush drops both entries and presents a bubble whose PC
// is captured from pc_in.
//
// Optional feature: define PIPE_STAGE_BUBBLE_CNT_EN to get a saturating
// 16-bit flush counter on bubble_cnt; otherwise bubble_cnt is tied to 0.
//
// Ports:
//   CLK        clock, all state on rising edge
//   reset      synchronous, active-high
//   flush      drop held entries, insert bubble (bubble PC <= pc_in)
//   in_valid   upstream beat valid          in_ready  buffer can accept (flop)
//   pc_in, instr_in, ctrl_in, data_in       upstream beat payload
//   out_valid  head holds a real instruction out_ready downstream accepts head
//   pc_out, instr_out, ctrl_out, data_out   head payload, or bubble when idle
//   bubble_cnt flush counter (0 when the counter is compiled out)

// One data channel: main/skid word pair, loads steered by the shared control.
module pipe_stage_lane #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              ld_main,
  input  logic              main_from_skid,
  input  logic              ld_skid,
  input  logic              main_v,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out
);
  logic [DATA_W-1:0] main_q, skid_q;

  // Payload needs no reset: it is only visible while main_v is set.
  always_ff @(posedge CLK) begin
    if (ld_main) main_q <= main_from_skid ? skid_q : d_in;
    if (ld_skid) skid_q <= d_in;
  end

  assign d_out = main_v ? main_q : '0;
endmodule

module pipe_stage_reg #(
  parameter int                PC_W        = 32,
  parameter int                INSTR_W     = 32,
  parameter int                CTRL_W      = 21,
  parameter int                DATA_W      = 32,
  parameter int                NUM_DATA    = 2,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = 21'h13800C
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_W-1:0]              pc_in,
  input  logic [INSTR_W-1:0]           instr_in,
  input  logic [CTRL_W-1:0]            ctrl_in,
  input  logic [NUM_DATA*DATA_W-1:0]   data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              pc_out,
  output logic [INSTR_W-1:0]           instr_out,
  output logic [CTRL_W-1:0]            ctrl_out,
  output logic [NUM_DATA*DATA_W-1:0]   data_out,
  output logic [15:0]                  bubble_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [CTRL_W-1:0]  ctrl;
  } entry_t;

  entry_t            main_q, skid_q, in_e;
  logic              main_v, skid_v, in_ready_q;
  logic [PC_W-1:0]   bpc_q;

  logic              accept, fire;
  logic              ld_main, main_from_skid, ld_skid;
  logic              main_v_nxt, skid_v_nxt;

  assign in_e = '{pc: pc_in, instr: instr_in, ctrl: ctrl_in};

  // A flush cycle discards both handshakes, so neither side may move data.
  assign accept = in_valid & in_ready_q & ~flush;
  assign fire   = main_v & out_ready & ~flush;

  always_comb begin
    ld_main        = 1'b0;
    main_from_skid = 1'b0;
    ld_skid        = 1'b0;
    main_v_nxt     = main_v;
    skid_v_nxt     = skid_v;
    if (fire && skid_v) begin
      // Skid advances into main; a same-cycle beat refills the skid.
      ld_main        = 1'b1;
      main_from_skid = 1'b1;
      main_v_nxt     = 1'b1;
      ld_skid        = accept;
      skid_v_nxt     = accept;
    end else if (!main_v || fire) begin
      // Skid is empty here; main is free (or freeing) for the new beat.
      ld_main    = accept;
      main_v_nxt = accept;
    end else begin
      // Main stalled. in_ready is low whenever the skid is full, so an
      // accept here always lands in an empty skid.
      ld_skid = accept;
      if (accept) skid_v_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
      bpc_q      <= '0;
    end else if (flush) begin
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
      bpc_q      <= pc_in;
    end else begin
      main_v     <= main_v_nxt;
      skid_v     <= skid_v_nxt;
      in_ready_q <= ~skid_v_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (ld_main) main_q <= main_from_skid ? skid_q : in_e;
    if (ld_skid) skid_q <= in_e;
  end

  // Data channels, channel 0 in the LSBs.
  for (genvar g = 0; g < NUM_DATA; g++) begin : g_lane
    pipe_stage_lane #(.DATA_W(DATA_W)) u_lane (
      .CLK            (CLK),
      .ld_main        (ld_main),
      .main_from_skid (main_from_skid),
      .ld_skid        (ld_skid),
      .main_v         (main_v),
      .d_in           (data_in[g*DATA_W +: DATA_W]),
      .d_out          (data_out[g*DATA_W +: DATA_W])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign pc_out    = main_v ? main_q.pc    : bpc_q;
  assign instr_out = main_v ? main_q.instr : '0;
  assign ctrl_out  = main_v ? main_q.ctrl  : BUBBLE_CTRL;

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  logic [15:0] bcnt_q;

  always_ff @(posedge CLK) begin
    if (reset)                          bcnt_q <= '0;
    else if (flush && bcnt_q != 16'hFFFF) bcnt_q <= bcnt_q + 16'd1;
  end

  assign bubble_cnt = bcnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver issues directed beats, the
// monitor keeps a reference queue of held beats and checks the outputs every
// cycle on the falling edge.
module tb_pipe_stage_reg;
  localparam logic [20:0] BUB = 21'h13800C;

  logic        CLK = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] pc_in, instr_in, pc_out, instr_out;
  logic [20:0] ctrl_in, ctrl_out;
  logic [63:0] data_in, data_out;
  logic [15:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [20:0] ctrl;
    logic [63:0] data;
  } beat_t;

  beat_t       q[$];
  logic [31:0] exp_bpc = '0;
  logic [15:0] exp_cnt = '0;

  always #5 CLK = ~CLK;

  pipe_stage_reg dut (
    .CLK(CLK), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instr_in(instr_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .instr_out(instr_out), .ctrl_out(ctrl_out), .data_out(data_out),
    .bubble_cnt(bubble_cnt)
  );

  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [20:0] ctrl_of(logic [31:0] pc);
    return pc[20:0] ^ 21'h0ABCDE;
  endfunction
  function automatic logic [63:0] data_of(logic [31:0] pc);
    return {pc + 32'h2000, pc + 32'h1000};
  endfunction
  function automatic logic [15:0] cnt_exp(int n);
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n > 0) ? 16'h0 : 16'h0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    pc_in    = pc;
    instr_in = instr_of(pc);
    ctrl_in  = ctrl_of(pc);
    data_in  = data_of(pc);
  endtask

  // Monitor: compare current outputs with the model, then advance the model
  // by what the coming rising edge will do.
  always @(negedge CLK) begin
    if (mon_en) begin
      int sz;
      beat_t b;
      sz = q.size();
      chk("in_ready", 64'(in_ready), 64'(sz < 2));
      chk("out_valid", 64'(out_valid), 64'(sz > 0));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(exp_cnt));
      if (sz > 0) begin
        chk("head_pc", 64'(pc_out), 64'(q[0].pc));
        chk("head_instr", 64'(instr_out), 64'(q[0].instr));
        chk("head_ctrl", 64'(ctrl_out), 64'(q[0].ctrl));
        chk("head_data", data_out, q[0].data);
      end else begin
        chk("bubble_pc", 64'(pc_out), 64'(exp_bpc));
        chk("bubble_ctrl", 64'(ctrl_out), 64'(BUB));
        chk("bubble_instr", 64'(instr_out), 64'h0);
        chk("bubble_data", data_out, 64'h0);
      end
      if (reset) begin
        q.delete();
        exp_bpc = '0;
        exp_cnt = '0;
      end else if (flush) begin
        q.delete();
        exp_bpc = pc_in;
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
      end else begin
        if (sz > 0 && out_ready) void'(q.pop_front());
        if (in_valid && sz < 2) begin
          b.pc = pc_in; b.instr = instr_in; b.ctrl = ctrl_in; b.data = data_in;
          q.push_back(b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0);
    step(); mon_en = 1'b1;
    step();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_ctrl", 64'(ctrl_out), 64'h13800C);
    chk("rst_pc", 64'(pc_out), 64'h0);
    chk("rst_cnt", 64'(bubble_cnt), 64'h0);
    reset = 1'b0;

    // Streaming
    drive(1'b1, 32'h100); step();
    chk("st0_pc", 64'(pc_out), 64'h100); chk("st0_rdy", 64'(in_ready), 64'h1);
    drive(1'b1, 32'h104); step();
    chk("st1_pc", 64'(pc_out), 64'h104); chk("st1_rdy", 64'(in_ready), 64'h1);
    drive(1'b1, 32'h108); step();
    chk("st2_pc", 64'(pc_out), 64'h108); chk("st2_rdy", 64'(in_ready), 64'h1);
    drive(1'b0, 32'h0); step();
    chk("st_drain", 64'(out_valid), 64'h0);

    // Back-pressure
    out_ready = 1'b0;
    drive(1'b1, 32'h200); step();
    chk("bp0_pc", 64'(pc_out), 64'h200); chk("bp0_rdy", 64'(in_ready), 64'h1);
    drive(1'b1, 32'h204); step();
    chk("bp1_pc", 64'(pc_out), 64'h200); chk("bp1_rdy", 64'(in_ready), 64'h0);
    drive(1'b1, 32'h208); step();
    chk("bp2_pc", 64'(pc_out), 64'h200); chk("bp2_rdy", 64'(in_ready), 64'h0);
    out_ready = 1'b1; step();
    chk("bp3_pc", 64'(pc_out), 64'h204); chk("bp3_rdy", 64'(in_ready), 64'h1);
    step();
    chk("bp4_pc", 64'(pc_out), 64'h208);
    drive(1'b0, 32'h0); step();
    chk("bp_drain", 64'(out_valid), 64'h0);

    // Flush with a full buffer
    out_ready = 1'b0;
    drive(1'b1, 32'h400); step();
    drive(1'b1, 32'h404); step();
    chk("fl_full", 64'(in_ready), 64'h0);
    flush = 1'b1; drive(1'b1, 32'h300); step();
    flush = 1'b0; drive(1'b0, 32'h0);
    chk("fl_valid", 64'(out_valid), 64'h0);
    chk("fl_pc", 64'(pc_out), 64'h300);
    chk("fl_ctrl", 64'(ctrl_out), 64'h13800C);
    chk("fl_instr", 64'(instr_out), 64'h0);
    chk("fl_data", data_out, 64'h0);
    chk("fl_rdy", 64'(in_ready), 64'h1);
    chk("fl_cnt1", 64'(bubble_cnt), 64'(cnt_exp(1)));
    out_ready = 1'b1;
    drive(1'b1, 32'h500); step();
    chk("pf_pc", 64'(pc_out), 64'h500); chk("pf_valid", 64'(out_valid), 64'h1);
    drive(1'b1, 32'h510); step();
    // Flush while both sides handshake: neither beat survives.
    flush = 1'b1; drive(1'b1, 32'h520); step();
    flush = 1'b0; drive(1'b0, 32'h0);
    chk("ff_valid", 64'(out_valid), 64'h0);
    chk("ff_pc", 64'(pc_out), 64'h520);
    step();
    chk("ff_idle", 64'(out_valid), 64'h0);

    // Flush and reset together
    reset = 1'b1; flush = 1'b1; drive(1'b1, 32'h600); step();
    reset = 1'b0; flush = 1'b0; drive(1'b0, 32'h0);
    chk("fr_pc", 64'(pc_out), 64'h0);
    chk("fr_valid", 64'(out_valid), 64'h0);
    chk("fr_rdy", 64'(in_ready), 64'h1);
    chk("fr_ctrl", 64'(ctrl_out), 64'h13800C);
    chk("fr_cnt", 64'(bubble_cnt), 64'h0);

    // Counter
    flush = 1'b1; drive(1'b0, 32'h700);
    step(); step(); step();
    flush = 1'b0;
    chk("cnt3", 64'(bubble_cnt), 64'(cnt_exp(3)));
    chk("cnt_pc", 64'(pc_out), 64'h700);
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    flush = 1'b1;
    repeat (65532) step();
    flush = 1'b0;
    chk("cnt_sat", 64'(bubble_cnt), 64'hFFFF);
    flush = 1'b1;
    repeat (4) step();
    flush = 1'b0;
    chk("cnt_hold", 64'(bubble_cnt), 64'hFFFF);
`endif
    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage CPU, the generalised successor to the fixed-width stage latches between MEM and WB. It carries PC, instruction, control word and NUM_DATA data words through a two-entry skid buffer with a valid/ready handshake, so downstream back-pressure stalls without a combinational ready path. It also supports flush with insertion of a configurable bubble control word. One instance sits between each pair of stages (IF/ID through MEM/WB).

## Interface
- PC_W, 32, program-counter width
- INSTR_W, 32, instruction width
- CTRL_W, 21, control-signal bundle width
- DATA_W, 32, width of each data channel
- NUM_DATA, 2, number of data channels (e.g. ALU result, memory read data); packed, channel 0 in LSBs
- BUBBLE_CTRL, 21'h13800C, control word presented for a bubble (no-write, PC-select default)

- CLK  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all held entries, insert bubble
- in_valid  in  1  upstream beat valid
- in_ready  out  1  registered; buffer can accept
- pc_in  in  PC_W
- instr_in  in  INSTR_W
- ctrl_in  in  CTRL_W
- data_in  in  NUM_DATA*DATA_W
- out_valid  out  1  head entry holds a real instruction
- out_ready  in  1  downstream accepts head
- pc_out, instr_out, ctrl_out, data_out  out  widths as inputs
- bubble_cnt  out  16  flush count (see Configuration)

## Operation
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- Accept: in_valid & in_ready. Fire: out_valid & out_ready.
- Empty main, or main firing: accepted beat goes into main (skid empty in that case).
- Main valid and not firing: accepted beat goes into skid.
- Main fires while skid valid: skid moves to main; a beat accepted that same cycle goes into skid.
- in_ready next cycle = ~skid_valid next cycle.
- When out_valid=0, outputs present a bubble: ctrl_out=BUBBLE_CTRL, instr_out=0, data_out=0, pc_out=bubble PC register.
- Flush: main and skid valid cleared; bubble PC register <= pc_in; any handshake in the flush cycle on either side is discarded. Upstream treats its beat as consumed. Downstream ignores its fire.
- Priority: reset > flush > handshake.
- Reset: both valids 0, in_ready=1, pc_out=0, instr_out=0, data_out=0, ctrl_out=BUBBLE_CTRL, bubble_cnt=0, out_valid=0.

## Timing
- Latency: beat accepted at edge N is on outputs and out_valid after edge N (empty buffer).
- Throughput: one beat per cycle while out_ready=1.
- in_ready is a flop output with no combinational path from out_ready. It falls the cycle after the skid fills and rises the cycle after the skid drains.
- Downstream stall with continuous input: exactly two beats absorbed, none lost.
- After a flush, out_valid=0 and in_ready=1 on the following cycle. A new beat accepted the cycle after flush appears one cycle later.
- Outputs are stable while out_valid & ~out_ready.

## Configuration
- PIPE_STAGE_BUBBLE_CNT_EN defined: bubble_cnt increments by 1 on each cycle with flush=1 and reset=0. It saturates at 16'hFFFF.
- Not defined: counter logic is absent and bubble_cnt is tied to 0.

## Test plan
- Reset: assert reset for 2 cycles, then release. Required: out_valid=0, in_ready=1, ctrl_out=21'h13800C, pc_out=0.
- Streaming: send pc 0x100, 0x104, 0x108 on consecutive cycles with out_ready=1. Required: they appear in order one cycle later, one per cycle, and in_ready stays 1.
- Back-pressure: out_ready=0, send 0x200, 0x204, 0x208. Required: 0x200 held on the outputs, 0x204 in the skid, in_ready=0 after the 2nd accept, and 0x208 not accepted. After raising out_ready: 0x200, 0x204, 0x208 appear in sequence.
- Flush with full buffer: flush with pc_in=0x300. Required: next cycle out_valid=0, pc_out=0x300, ctrl_out=BUBBLE_CTRL, instr_out=0, in_ready=1.
- Flush and reset together: assert both. Required: the reset values are produced and pc_out=0.
- Counter (macro defined): 3 flushes. Required: bubble_cnt=3. With the counter preloaded near saturation, it holds at 0xFFFF. With the macro undefined, bubble_cnt=0 throughout.
